// File: rtl/kisc_alu.sv
// KISC-V RV32I integer ALU: combinational result and branch flag, plus optional
// registered copies enabled by defining KISC_ALU_OUT_REG_EN.
module kisc_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  cmp_flag,
    input  logic                  clk,
    input  logic                  rts,
    output logic [DATA_WIDTH-1:0] alu_out_q,
    output logic                  cmp_flag_q
);
    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0]        w_shamt;
    logic                  w_eq;
    logic                  w_lt;
    logic                  w_ltu;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_flag;

    assign w_shamt = b[SHW-1:0];
    assign w_eq    = (a == b);
    assign w_lt    = ($signed(a) < $signed(b));
    assign w_ltu   = (a < b);

    // Bit 3 only selects SUB and SRA; every other funct3 ignores it.
    always_comb begin
        w_result = '0;
        case (alu_op[2:0])
            3'b000: w_result = alu_op[3] ? (a - b) : (a + b);
            3'b001: w_result = a << w_shamt;
            3'b010: w_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            3'b011: w_result = {{(DATA_WIDTH-1){1'b0}}, w_ltu};
            3'b100: w_result = a ^ b;
            3'b101: w_result = alu_op[3] ? $unsigned($signed(a) >>> w_shamt)
                                         : (a >> w_shamt);
            3'b110: w_result = a | b;
            3'b111: w_result = a & b;
            default: w_result = '0;
        endcase
    end

    // Bit 3 carries imm[30] on branches, so the flag decodes funct3 only.
    always_comb begin
        w_flag = 1'b0;
        case (alu_op[2:0])
            3'b000: w_flag = w_eq;
            3'b001: w_flag = ~w_eq;
            3'b010: w_flag = w_lt;
            3'b011: w_flag = w_ltu;
            3'b100: w_flag = w_lt;
            3'b101: w_flag = ~w_lt;
            3'b110: w_flag = w_ltu;
            3'b111: w_flag = ~w_ltu;
            default: w_flag = 1'b0;
        endcase
    end

    assign alu_out  = w_result;
    assign cmp_flag = w_flag;

`ifdef KISC_ALU_OUT_REG_EN
    logic [DATA_WIDTH-1:0] r_alu_out;
    logic                  r_cmp_flag;

    always_ff @(posedge clk or posedge rts) begin
        if (rts) begin
            r_alu_out  <= '0;
            r_cmp_flag <= 1'b0;
        end else begin
            r_alu_out  <= w_result;
            r_cmp_flag <= w_flag;
        end
    end

    assign alu_out_q  = r_alu_out;
    assign cmp_flag_q = r_cmp_flag;
`else
    // No flops in this build; clk/rts stay on the port list for a common footprint.
    logic w_unused_clk_rts;
    assign w_unused_clk_rts = clk ^ rts;
    assign alu_out_q  = w_result;
    assign cmp_flag_q = w_flag;
`endif

endmodule

// File: tb/tb_kisc_alu.sv
// Scoreboard bench for kisc_alu: directed vectors queued by a driver, checked
// by an independent negedge monitor; register/reset checks when the macro is set.
module tb_kisc_alu;
    logic        clk = 1'b0;
    logic        rts = 1'b1;
    logic [3:0]  alu_op = 4'b0000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] alu_out;
    logic        cmp_flag;
    logic [31:0] alu_out_q;
    logic        cmp_flag_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic        flag;
    } exp_t;

    exp_t exp_q[$];
    exp_t prev;
    bit   prev_vld = 1'b0;

    kisc_alu dut (
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .alu_out   (alu_out),
        .cmp_flag  (cmp_flag),
        .clk       (clk),
        .rts       (rts),
        .alu_out_q (alu_out_q),
        .cmp_flag_q(cmp_flag_q)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, req);
        end
    endtask

    // Monitor: every driven vector is compared on the negedge of its cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk32({e.name, " out"}, alu_out, e.out);
            chk1({e.name, " flag"}, cmp_flag, e.flag);
`ifdef KISC_ALU_OUT_REG_EN
            if (prev_vld) begin
                chk32({prev.name, " out_q"}, alu_out_q, prev.out);
                chk1({prev.name, " flag_q"}, cmp_flag_q, prev.flag);
            end
            prev     = e;
            prev_vld = 1'b1;
`else
            chk32({e.name, " out_q"}, alu_out_q, e.out);
            chk1({e.name, " flag_q"}, cmp_flag_q, e.flag);
`endif
        end
    end

    task automatic drive(input string nm, input logic [3:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] eo, input logic ef);
        exp_t e;
        @(posedge clk);
        #1;
        alu_op = op;
        a      = va;
        b      = vb;
        e.name = nm;
        e.out  = eo;
        e.flag = ef;
        exp_q.push_back(e);
    endtask

    initial begin
        #2;
`ifdef KISC_ALU_OUT_REG_EN
        chk32("reset out_q", alu_out_q, 32'h0);
        chk1("reset flag_q", cmp_flag_q, 1'b0);
`else
        chk32("reset out_q", alu_out_q, 32'h0);
        chk1("reset flag_q", cmp_flag_q, 1'b1);
`endif
        chk32("reset comb out", alu_out, 32'h0);
        chk1("reset comb flag", cmp_flag, 1'b1);
        @(negedge clk);
        rts = 1'b0;

        drive("add_wrap",  4'b0000, 32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b0);
        drive("sub_wrap",  4'b1000, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0);
        drive("srl",       4'b0101, 32'h80000000, 32'h21,       32'h40000000, 1'b0);
        drive("sra",       4'b1101, 32'h80000000, 32'h21,       32'hC0000000, 1'b0);
        drive("sll31",     4'b0001, 32'h1,        32'd31,       32'h80000000, 1'b1);
        drive("slt",       4'b0010, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b1);
        drive("sltu",      4'b0011, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0);
        drive("xor_blt",   4'b0100, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b1);
        drive("or_bltu",   4'b0110, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 1'b0);
        drive("beq",       4'b0000, 32'd5,        32'd5,        32'h0000000A, 1'b1);
        drive("bne",       4'b0001, 32'd5,        32'd5,        32'h000000A0, 1'b0);
        drive("bge",       4'b0101, 32'd5,        32'd5,        32'h00000000, 1'b1);
        drive("bgeu",      4'b1111, 32'd5,        32'd5,        32'h00000005, 1'b1);
        drive("bge_b3",    4'b1101, 32'd5,        32'd5,        32'h00000000, 1'b1);
        drive("xor",       4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b1);
        drive("or",        4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0);
        drive("and",       4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b1);
        drive("slt_b3",    4'b1010, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b1);
        drive("sll_sh0",   4'b0001, 32'h12345678, 32'h20,       32'h12345678, 1'b1);
        drive("xor_b3",    4'b1100, 32'd3,        32'd5,        32'h6,        1'b1);
        drive("sltu_b3",   4'b1011, 32'd1,        32'd2,        32'h1,        1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        chk32("scoreboard drained", 32'(exp_q.size()), 32'h0);

`ifdef KISC_ALU_OUT_REG_EN
        // Register and reset behaviour, driven directly.
        @(posedge clk); #1;
        alu_op = 4'b0000; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        chk32("reg 2+3 out_q", alu_out_q, 32'd5);
        chk1("reg 2+3 flag_q", cmp_flag_q, 1'b0);
        a = 32'd4; b = 32'd4;
        @(posedge clk); #1;
        chk32("reg 4+4 out_q", alu_out_q, 32'd8);
        chk1("reg 4+4 flag_q", cmp_flag_q, 1'b1);
        @(negedge clk);
        rts = 1'b1;
        #1;
        chk32("rts async out_q", alu_out_q, 32'd0);
        chk1("rts async flag_q", cmp_flag_q, 1'b0);
        chk32("rts comb out", alu_out, 32'd8);
        @(posedge clk); #1;
        chk32("rts hold out_q", alu_out_q, 32'd0);
        chk1("rts hold flag_q", cmp_flag_q, 1'b0);
        @(negedge clk);
        rts = 1'b0;
        #1;
        chk32("rts release pre-edge", alu_out_q, 32'd0);
        @(posedge clk); #1;
        chk32("reload out_q", alu_out_q, 32'd8);
        chk1("reload flag_q", cmp_flag_q, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
